// File: rtl/atm_req_if.sv
// -----------------------------------------------------------------------------
// atm_req_if
// Purpose : Transaction request bus between the keypad entry front-end and the
//           ATM controller FSM. The request fields are qualified by req_valid.
//           A request transfers on any cycle where req_valid & req_ready.
// Signals :
//   req_valid  1   request complete and stable (producer -> consumer)
//   req_ready  1   consumer accepts request     (consumer -> producer)
//   acc_num    4   account index, binary 0-9
//   pin        16  PIN, packed BCD, first digit in [15:12]
//   new_pin    16  new PIN, packed BCD (CHANGE_PIN only)
//   operation  3   1 BALANCE, 2 WITHDRAW, 3 DEPOSIT, 4 CHANGE_PIN
//   amount     32  binary amount (WITHDRAW / DEPOSIT only)
// Modports: master = request producer (keypad entry), slave = controller.
// -----------------------------------------------------------------------------
interface atm_req_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic [15:0] new_pin;
    logic [2:0]  operation;
    logic [31:0] amount;

    modport master (
        output req_valid, acc_num, pin, new_pin, operation, amount,
        input  req_ready
    );

    modport slave (
        input  req_valid, acc_num, pin, new_pin, operation, amount,
        output req_ready
    );
endinterface

// File: rtl/atm_keypad_entry.sv
// -----------------------------------------------------------------------------
// atm_keypad_entry
// Purpose : Keypad front-end of the ATM controller. Collects key presses into
//           account number, PIN, operation, amount and new PIN, validates each
//           field, handles CLEAR / CANCEL / inactivity timeout, and presents a
//           well-formed request on a valid/ready handshake.
// Ports   :
//   clk            in   system clock
//   rst            in   asynchronous, active-low reset
//   i_key_valid    in   one-cycle strobe, i_key_code valid
//   i_key_code     in   0-9 digit, 10 ENTER, 11 CLEAR, 12 CANCEL, 13-15 illegal
//   req_if         --   request bus (master side), see atm_req_if
//   o_entry_state  out  state code: ACCT=0 PIN=1 OP=2 AMOUNT=3 NEWPIN=4 ISSUE=5
//   o_error        out  one-cycle pulse on a rejected key or field
//   o_timeout      out  one-cycle pulse when a partial entry is abandoned
// -----------------------------------------------------------------------------
module atm_keypad_entry #(
    parameter int TIMEOUT_CYCLES    = 1000,
    parameter int MAX_AMOUNT_DIGITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_key_valid,
    input  logic [3:0] i_key_code,
    atm_req_if.master  req_if,
    output logic [2:0] o_entry_state,
    output logic       o_error,
    output logic       o_timeout
);

    typedef enum logic [2:0] {
        ST_ACCT   = 3'd0,
        ST_PIN    = 3'd1,
        ST_OP     = 3'd2,
        ST_AMOUNT = 3'd3,
        ST_NEWPIN = 3'd4,
        ST_ISSUE  = 3'd5
    } state_t;

    localparam int            TW         = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT_CYCLES - 1);

    state_t        r_state,   w_state_nxt;
    logic [3:0]    r_acc,     w_acc_nxt;
    logic [15:0]   r_pin,     w_pin_nxt;
    logic [2:0]    r_op,      w_op_nxt;
    logic [31:0]   r_amount,  w_amount_nxt;
    logic [15:0]   r_new_pin, w_new_pin_nxt;
    logic [3:0]    r_cnt,     w_cnt_nxt;    // digits in the field being entered
    logic [TW-1:0] r_idle,    w_idle_nxt;   // inactivity counter
    logic          r_error,   w_error_nxt;
    logic          r_timeout, w_timeout_nxt;

    logic          w_clear_field;           // wipe only the current field
    logic          w_clear_all;             // wipe everything, back to ACCT
    logic          w_is_digit;
    logic          w_enter;
    logic          w_clear;
    logic          w_cancel;
    logic [31:0]   w_amount_step;

    assign w_is_digit = (i_key_code <= 4'd9);
    assign w_enter    = (i_key_code == 4'd10);
    assign w_clear    = (i_key_code == 4'd11);
    assign w_cancel   = (i_key_code == 4'd12);

    // amount*10 + d built from shifts; wraps modulo 2^32 by construction.
    assign w_amount_step = (r_amount << 3) + (r_amount << 1) + {28'd0, i_key_code};

    always_comb begin
        // NOTE: every variable written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_pin_nxt     = r_pin;
        w_op_nxt      = r_op;
        w_amount_nxt  = r_amount;
        w_new_pin_nxt = r_new_pin;
        w_cnt_nxt     = r_cnt;
        w_idle_nxt    = r_idle;
        w_error_nxt   = 1'b0;
        w_timeout_nxt = 1'b0;
        w_clear_field = 1'b0;
        w_clear_all   = 1'b0;

        if (r_state == ST_ISSUE) begin
            // Keys are ignored and the idle counter is frozen while issuing.
            if (req_if.req_ready) begin
                w_clear_all = 1'b1;
            end
        end else if (i_key_valid) begin
            // A key arriving on the expiry cycle wins over the timeout.
            w_idle_nxt = '0;
            if (w_cancel) begin
                w_clear_all = 1'b1;
            end else if (w_clear) begin
                w_clear_field = 1'b1;
            end else if (!w_is_digit && !w_enter) begin
                w_error_nxt = 1'b1;
            end else begin
                unique case (r_state)
                    ST_ACCT: begin
                        if (w_enter) begin
                            if (r_cnt == 4'd1) begin
                                w_state_nxt = ST_PIN;
                                w_cnt_nxt   = '0;
                            end else begin
                                w_error_nxt   = 1'b1;
                                w_clear_field = 1'b1;
                            end
                        end else if (r_cnt == 4'd0) begin
                            w_acc_nxt = i_key_code;
                            w_cnt_nxt = 4'd1;
                        end else begin
                            w_error_nxt = 1'b1;
                        end
                    end
                    ST_PIN, ST_NEWPIN: begin
                        if (w_enter) begin
                            if (r_cnt == 4'd4) begin
                                w_state_nxt = (r_state == ST_PIN) ? ST_OP : ST_ISSUE;
                                w_cnt_nxt   = '0;
                            end else begin
                                w_error_nxt   = 1'b1;
                                w_clear_field = 1'b1;
                            end
                        end else if (r_cnt < 4'd4) begin
                            if (r_state == ST_PIN) begin
                                w_pin_nxt = {r_pin[11:0], i_key_code};
                            end else begin
                                w_new_pin_nxt = {r_new_pin[11:0], i_key_code};
                            end
                            w_cnt_nxt = r_cnt + 4'd1;
                        end else begin
                            w_error_nxt = 1'b1;
                        end
                    end
                    ST_OP: begin
                        if (w_enter) begin
                            if (r_cnt == 4'd1) begin
                                w_cnt_nxt = '0;
                                // Only 1-4 can be stored, so 2/3 fall to AMOUNT.
                                unique case (r_op)
                                    3'd1:    w_state_nxt = ST_ISSUE;
                                    3'd4:    w_state_nxt = ST_NEWPIN;
                                    default: w_state_nxt = ST_AMOUNT;
                                endcase
                            end else begin
                                w_error_nxt   = 1'b1;
                                w_clear_field = 1'b1;
                            end
                        end else if (r_cnt == 4'd0 && i_key_code >= 4'd1 && i_key_code <= 4'd4) begin
                            w_op_nxt  = i_key_code[2:0];
                            w_cnt_nxt = 4'd1;
                        end else begin
                            w_error_nxt = 1'b1;
                        end
                    end
                    ST_AMOUNT: begin
                        if (w_enter) begin
                            if (r_cnt != 4'd0 && r_amount != 32'd0) begin
                                w_state_nxt = ST_ISSUE;
                                w_cnt_nxt   = '0;
                            end else begin
                                w_error_nxt   = 1'b1;
                                w_clear_field = 1'b1;
                            end
                        end else if (int'(r_cnt) < MAX_AMOUNT_DIGITS) begin
                            w_amount_nxt = w_amount_step;
                            w_cnt_nxt    = r_cnt + 4'd1;
                        end else begin
                            w_error_nxt = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (r_state == ST_ACCT && r_cnt == 4'd0) begin
            // Nothing entered yet: there is no partial entry to abandon.
            w_idle_nxt = '0;
        end else if (r_idle + TW'(1) == IDLE_LIMIT) begin
            w_timeout_nxt = 1'b1;
            w_clear_all   = 1'b1;
        end else begin
            w_idle_nxt = r_idle + TW'(1);
        end

        if (w_clear_field) begin
            w_cnt_nxt = '0;
            unique case (r_state)
                ST_ACCT:   w_acc_nxt     = '0;
                ST_PIN:    w_pin_nxt     = '0;
                ST_OP:     w_op_nxt      = '0;
                ST_AMOUNT: w_amount_nxt  = '0;
                ST_NEWPIN: w_new_pin_nxt = '0;
                default: ;
            endcase
        end

        if (w_clear_all) begin
            w_state_nxt   = ST_ACCT;
            w_acc_nxt     = '0;
            w_pin_nxt     = '0;
            w_op_nxt      = '0;
            w_amount_nxt  = '0;
            w_new_pin_nxt = '0;
            w_cnt_nxt     = '0;
            w_idle_nxt    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_ACCT;
            r_acc     <= '0;
            r_pin     <= '0;
            r_op      <= '0;
            r_amount  <= '0;
            r_new_pin <= '0;
            r_cnt     <= '0;
            r_idle    <= '0;
            r_error   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            r_state   <= w_state_nxt;
            r_acc     <= w_acc_nxt;
            r_pin     <= w_pin_nxt;
            r_op      <= w_op_nxt;
            r_amount  <= w_amount_nxt;
            r_new_pin <= w_new_pin_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idle    <= w_idle_nxt;
            r_error   <= w_error_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign req_if.req_valid = (r_state == ST_ISSUE);
    assign req_if.acc_num   = r_acc;
    assign req_if.pin       = r_pin;
    assign req_if.new_pin   = r_new_pin;
    assign req_if.operation = r_op;
    assign req_if.amount    = r_amount;
    assign o_entry_state    = r_state;
    assign o_error          = r_error;
    assign o_timeout        = r_timeout;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// -----------------------------------------------------------------------------
// tb_atm_keypad_entry
// Purpose : Self-checking bench for atm_keypad_entry (TIMEOUT_CYCLES=20).
//           Table-driven vectors, hand-written multi-cycle sequences, and a
//           randomized phase compared against a field-level reference model.
// -----------------------------------------------------------------------------
module tb_atm_keypad_entry;

    localparam int TO   = 20;
    localparam int MAXD = 8;

    logic       clk;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic [2:0] entry_state;
    logic       error;
    logic       timeout;

    atm_req_if rq();

    atm_keypad_entry #(
        .TIMEOUT_CYCLES    (TO),
        .MAX_AMOUNT_DIGITS (MAXD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_key_valid   (key_valid),
        .i_key_code    (key_code),
        .req_if        (rq),
        .o_entry_state (entry_state),
        .o_error       (error),
        .o_timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [76:0] act, input logic [76:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {state, error, timeout, req_valid, acc, op, pin, new_pin, amount}
    function automatic logic [76:0] dut_pack();
        return {entry_state, error, timeout, rq.req_valid, rq.acc_num, rq.operation,
                rq.pin, rq.new_pin, rq.amount};
    endfunction

    // ---------------- reference model (field level) ----------------
    int          m_state;
    int          m_buf[$];      // digits typed into the current field
    logic [3:0]  m_acc;
    logic [15:0] m_pin;
    logic [15:0] m_npin;
    logic [2:0]  m_op;
    logic [31:0] m_amt;
    int          m_quiet;       // cycles since last key / since entry started
    logic        m_err;
    logic        m_to;

    function automatic logic [15:0] bcd_of(input int q[$]);
        logic [15:0] v;
        v = '0;
        foreach (q[i]) v = v * 16'd16 + 16'(q[i]);
        return v;
    endfunction

    function automatic logic [31:0] dec_of(input int q[$]);
        logic [31:0] v;
        v = '0;
        foreach (q[i]) v = v * 32'd10 + 32'(q[i]);
        return v;
    endfunction

    function automatic void model_clear_all();
        m_state = 0;
        m_buf.delete();
        m_acc = '0; m_pin = '0; m_npin = '0; m_op = '0; m_amt = '0;
    endfunction

    function automatic void model_reset();
        model_clear_all();
        m_quiet = 0; m_err = 1'b0; m_to = 1'b0;
    endfunction

    function automatic void model_enter();
        int  n;
        bit  ok;
        n = m_buf.size();
        case (m_state)
            0, 2:    ok = (n == 1);
            1, 4:    ok = (n == 4);
            default: ok = (n >= 1) && (dec_of(m_buf) != 0);
        endcase
        if (!ok) begin
            m_err = 1'b1;
            m_buf.delete();
            return;
        end
        case (m_state)
            0: begin m_acc = 4'(m_buf[0]); m_state = 1; end
            1: begin m_pin = bcd_of(m_buf); m_state = 2; end
            2: begin
                m_op = 3'(m_buf[0]);
                m_state = (m_buf[0] == 1) ? 5 : (m_buf[0] == 4) ? 4 : 3;
            end
            3: begin m_amt = dec_of(m_buf); m_state = 5; end
            default: begin m_npin = bcd_of(m_buf); m_state = 5; end
        endcase
        m_buf.delete();
    endfunction

    function automatic void model_key(input int k);
        int cap;
        if (k >= 13) m_err = 1'b1;
        else if (k == 12) model_clear_all();
        else if (k == 11) m_buf.delete();
        else if (k == 10) model_enter();
        else begin
            cap = (m_state == 3) ? MAXD : (m_state == 1 || m_state == 4) ? 4 : 1;
            if (m_buf.size() >= cap || (m_state == 2 && (k < 1 || k > 4))) m_err = 1'b1;
            else m_buf.push_back(k);
        end
    endfunction

    function automatic void model_step(input int kv, input int kc, input int rdy);
        m_err = 1'b0;
        m_to  = 1'b0;
        if (m_state == 5) begin
            if (rdy != 0) model_clear_all();
        end else if (kv != 0) begin
            m_quiet = 0;
            model_key(kc);
        end else if (m_state == 0 && m_buf.size() == 0) begin
            m_quiet = 0;
        end else begin
            m_quiet++;
            if (m_quiet == TO - 1) begin
                m_to = 1'b1;
                model_clear_all();
                m_quiet = 0;
            end
        end
    endfunction

    function automatic logic [76:0] model_pack();
        logic [3:0]  acc;
        logic [2:0]  op;
        logic [15:0] pin;
        logic [15:0] npin;
        logic [31:0] amt;
        acc = m_acc; op = m_op; pin = m_pin; npin = m_npin; amt = m_amt;
        case (m_state)
            0: acc  = (m_buf.size() != 0) ? 4'(m_buf[0]) : 4'd0;
            1: pin  = bcd_of(m_buf);
            2: op   = (m_buf.size() != 0) ? 3'(m_buf[0]) : 3'd0;
            3: amt  = dec_of(m_buf);
            4: npin = bcd_of(m_buf);
            default: ;
        endcase
        return {3'(m_state), m_err, m_to, (m_state == 5), acc, op, pin, npin, amt};
    endfunction

    // ---------------- stimulus helpers ----------------
    // Called 1 time unit after a rising edge; returns 1 unit after the next.
    task automatic drive(input int kv, input int kc, input int rdy);
        key_valid    = (kv != 0);
        key_code     = 4'(kc);
        rq.req_ready = (rdy != 0);
        @(posedge clk);
        model_step(kv, kc, rdy);
        #1;
    endtask

    // E=ENTER, C=CLEAR, X=CANCEL, digits as themselves.
    task automatic keys(input string s, input int rdy);
        for (int i = 0; i < s.len(); i++) begin
            int k;
            case (s[i])
                "E":     k = 10;
                "C":     k = 11;
                "X":     k = 12;
                default: k = int'(s[i]) - 48;
            endcase
            drive(1, k, rdy);
        end
    endtask

    task automatic do_reset(input string name);
        rst          = 1'b0;
        key_valid    = 1'b0;
        key_code     = 4'd0;
        rq.req_ready = 1'b0;
        #2;
        model_reset();
        check({name, "_async"}, dut_pack(), 77'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        model_step(0, 0, 0);
        #1;
        check({name, "_release"}, dut_pack(), 77'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          kv;
        int          kc;
        int          rdy;
        logic [2:0]  st;
        logic        err;
        logic        rv;
        logic [3:0]  acc;
        logic [2:0]  op;
        logic [15:0] pin;
        logic [15:0] npin;
        logic [31:0] amt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int kv, input int kc, input int rdy, input int st, input int err,
                       input int rv, input int acc, input int op, input int pin, input int amt);
        vec_t v;
        v.kv = kv; v.kc = kc; v.rdy = rdy;
        v.st = 3'(st); v.err = (err != 0); v.rv = (rv != 0);
        v.acc = 4'(acc); v.op = 3'(op); v.pin = 16'(pin); v.npin = '0; v.amt = 32'(amt);
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] nines;
        int          pct;
        int          r;
        int          kv;
        int          kc;

        key_valid    = 1'b0;
        key_code     = 4'd0;
        rq.req_ready = 1'b0;
        do_reset("reset");

        // Withdraw 500 with ready held high, then field error cases.
        add(1, 3, 1,  0,0,0, 3,0, 'h0000,   0);
        add(1,10, 1,  1,0,0, 3,0, 'h0000,   0);
        add(1, 1, 1,  1,0,0, 3,0, 'h0001,   0);
        add(1, 2, 1,  1,0,0, 3,0, 'h0012,   0);
        add(1, 3, 1,  1,0,0, 3,0, 'h0123,   0);
        add(1, 4, 1,  1,0,0, 3,0, 'h1234,   0);
        add(1,10, 1,  2,0,0, 3,0, 'h1234,   0);
        add(1, 2, 1,  2,0,0, 3,2, 'h1234,   0);
        add(1,10, 1,  3,0,0, 3,2, 'h1234,   0);
        add(1, 5, 1,  3,0,0, 3,2, 'h1234,   5);
        add(1, 0, 1,  3,0,0, 3,2, 'h1234,  50);
        add(1, 0, 1,  3,0,0, 3,2, 'h1234, 500);
        add(1,10, 1,  5,0,1, 3,2, 'h1234, 500);
        add(0, 0, 1,  0,0,0, 0,0, 'h0000,   0);
        add(1, 1, 1,  0,0,0, 1,0, 'h0000,   0);
        add(1,10, 1,  1,0,0, 1,0, 'h0000,   0);
        add(1, 1, 1,  1,0,0, 1,0, 'h0001,   0);
        add(1, 2, 1,  1,0,0, 1,0, 'h0012,   0);
        add(1, 3, 1,  1,0,0, 1,0, 'h0123,   0);
        add(1,10, 1,  1,1,0, 1,0, 'h0000,   0);
        add(1, 1, 1,  1,0,0, 1,0, 'h0001,   0);
        add(1, 2, 1,  1,0,0, 1,0, 'h0012,   0);
        add(1, 3, 1,  1,0,0, 1,0, 'h0123,   0);
        add(1, 4, 1,  1,0,0, 1,0, 'h1234,   0);
        add(1, 5, 1,  1,1,0, 1,0, 'h1234,   0);
        add(1,10, 1,  2,0,0, 1,0, 'h1234,   0);
        add(1, 6, 1,  2,1,0, 1,0, 'h1234,   0);
        add(1, 2, 1,  2,0,0, 1,2, 'h1234,   0);
        add(1,10, 1,  3,0,0, 1,2, 'h1234,   0);
        add(1,10, 1,  3,1,0, 1,2, 'h1234,   0);
        nines = '0;
        for (int i = 1; i <= 9; i++) begin
            if (i <= MAXD) nines = nines * 32'd10 + 32'd9;
            add(1, 9, 1, 3, (i > MAXD) ? 1 : 0, 0, 1, 2, 'h1234, int'(nines));
        end
        add(1,11, 1,  3,0,0, 1,2, 'h1234,   0);
        add(1,14, 1,  3,1,0, 1,2, 'h1234,   0);
        add(1,12, 1,  0,0,0, 0,0, 'h0000,   0);
        add(1, 7, 1,  0,0,0, 7,0, 'h0000,   0);
        add(1, 8, 1,  0,1,0, 7,0, 'h0000,   0);
        add(1,11, 1,  0,0,0, 0,0, 'h0000,   0);
        add(1,10, 1,  0,1,0, 0,0, 'h0000,   0);
        add(1,15, 1,  0,1,0, 0,0, 'h0000,   0);

        foreach (vecs[i]) begin
            drive(vecs[i].kv, vecs[i].kc, vecs[i].rdy);
            check($sformatf("vec%0d", i), dut_pack(),
                  {vecs[i].st, vecs[i].err, 1'b0, vecs[i].rv, vecs[i].acc, vecs[i].op,
                   vecs[i].pin, vecs[i].npin, vecs[i].amt});
        end

        // CHANGE_PIN held in ISSUE while ready is low; keys are ignored there.
        keys("7E9999E4E4321E", 0);
        for (int i = 0; i < 6; i++) begin
            check("issue_hold", dut_pack(),
                  {3'd5, 1'b0, 1'b0, 1'b1, 4'd7, 3'd4, 16'h9999, 16'h4321, 32'd0});
            drive(1, (i == 0) ? 12 : (i == 1) ? 5 : (i == 2) ? 13 : 10, 0);
        end
        check("issue_last", dut_pack(),
              {3'd5, 1'b0, 1'b0, 1'b1, 4'd7, 3'd4, 16'h9999, 16'h4321, 32'd0});
        drive(0, 0, 1);
        check("issue_drop", dut_pack(), 77'd0);

        // Inactivity timeout fires 19 cycles after the last key.
        keys("1E1", 0);
        for (int i = 1; i < TO - 1; i++) begin
            drive(0, 0, 0);
            check("to_wait", 77'({timeout, entry_state}), 77'({1'b0, 3'd1}));
        end
        drive(0, 0, 0);
        check("to_fire", 77'({timeout, error, entry_state, rq.pin}), 77'({1'b1, 1'b0, 3'd0, 16'h0}));
        drive(0, 0, 0);
        check("to_pulse", 77'({timeout, entry_state}), 77'd0);

        // A key on the expiry cycle wins.
        keys("1E1", 0);
        for (int i = 1; i < TO - 1; i++) drive(0, 0, 0);
        drive(1, 2, 0);
        check("to_key_wins", 77'({timeout, error, entry_state, rq.pin}), 77'({1'b0, 1'b0, 3'd1, 16'h0012}));
        keys("X", 0);

        // Reset mid-AMOUNT and mid-ISSUE.
        keys("1E1234E2E5", 0);
        check("amount_pre", 77'({entry_state, rq.amount}), 77'({3'd3, 32'd5}));
        do_reset("rst_amount");
        keys("2E1111E1E", 0);
        check("issue_pre", 77'({rq.req_valid, entry_state}), 77'({1'b1, 3'd5}));
        do_reset("rst_issue");
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1);
            check("no_req_after_rst", 77'({rq.req_valid, entry_state}), 77'd0);
        end

        // CANCEL in NEWPIN.
        keys("1E1234E4E56", 0);
        check("newpin_pre", 77'({entry_state, rq.new_pin}), 77'({3'd4, 16'h0056}));
        keys("X", 0);
        check("newpin_cancel", dut_pack(), 77'd0);

        // Randomized phase against the reference model.
        do_reset("rst_random");
        for (int blk = 0; blk < 21; blk++) begin
            pct = (blk % 3 == 0) ? 4 : (blk % 3 == 1) ? 50 : 90;
            for (int c = 0; c < 200; c++) begin
                kv = ($urandom_range(0, 99) < pct) ? 1 : 0;
                r  = $urandom_range(0, 19);
                if (r < 12)       kc = $urandom_range(0, 9);
                else if (r < 16)  kc = 10;
                else if (r == 16) kc = 11;
                else if (r == 17) kc = 12;
                else if (r == 18) kc = $urandom_range(13, 15);
                else              kc = $urandom_range(1, 4);
                drive(kv, kc, ($urandom_range(0, 3) == 0) ? 1 : 0);
                check("random", dut_pack(), model_pack());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/atm_keypad_entry.md
Name: atm_keypad_entry

Overview:
- Upstream front-end of the ATM controller: collects keypad presses and assembles one complete transaction request.
- The request carries account number, 4-digit PIN, operation, amount and new PIN.
- The request is presented to the ATM FSM through a valid/ready handshake.
- Handles field validation, clear/cancel and inactivity timeout, so the controller only ever sees well-formed requests.

Parameters:
- TIMEOUT_CYCLES, 1000: idle cycles without a key press before a partial entry is abandoned.
- MAX_AMOUNT_DIGITS, 8: maximum decimal digits accepted in the amount field (8 digits fits 32 bits).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- key_valid  in  1  one-cycle strobe, key_code valid
- key_code  in  4  0-9 digit, 10 ENTER, 11 CLEAR, 12 CANCEL, 13-15 illegal
- req_valid  out  1  request complete and stable
- req_ready  in  1  controller accepts request
- acc_num  out  4  account index, binary 0-9
- pin  out  16  PIN, packed BCD, first digit in [15:12]
- new_pin  out  16  new PIN, packed BCD, zero unless operation=4
- operation  out  3  1 BALANCE, 2 WITHDRAW, 3 DEPOSIT, 4 CHANGE_PIN
- amount  out  32  binary amount, zero unless operation is 2 or 3
- entry_state  out  3  current FSM state code (below)
- error  out  1  one-cycle pulse on rejected key/field
- timeout  out  1  one-cycle pulse when entry abandoned

Behaviour:
- Reset (async, rst=0):
  - state=ACCT; all outputs 0; digit counters and timeout counter 0.
- States/codes: ACCT=0, PIN=1, OP=2, AMOUNT=3, NEWPIN=4, ISSUE=5. All key processing is registered; field registers and state update on the edge after key_valid.
- ACCT:
  - Accepts exactly 1 digit into acc_num.
  - ENTER with 1 digit -> PIN.
  - A second digit is ignored and pulses error.
- PIN:
  - Each digit shifts in: pin <= {pin[11:0], d}. More than 4 digits: ignored, error.
  - ENTER with exactly 4 digits -> OP.
- OP:
  - Accepts 1 digit, legal values 1-4; digit 0 or 5-9 -> error, field unchanged.
  - ENTER: op 1 -> ISSUE; op 2/3 -> AMOUNT; op 4 -> NEWPIN.
- AMOUNT:
  - Each digit: amount <= amount*10 + d, 32-bit unsigned.
  - Digits beyond MAX_AMOUNT_DIGITS: ignored, error.
  - ENTER with >=1 digit and amount != 0 -> ISSUE; otherwise error, field cleared.
- NEWPIN: same rules as PIN into new_pin; ENTER with 4 digits -> ISSUE.
- ENTER with wrong digit count in any entry state: error pulse, current field and its counter cleared, state held.
- CLEAR: clears current field and its digit counter only; no error.
- CANCEL (any entry state): all fields cleared, state -> ACCT, no error.
- key_code 13-15: ignored, error pulse.
- ISSUE:
  - req_valid=1; all field outputs held stable.
  - All keys ignored (no error); timeout counter frozen.
  - Transfer occurs on the cycle req_valid & req_ready. Next cycle: req_valid=0, all fields cleared, state ACCT.
  - req_ready while not in ISSUE has no effect.
- Timeout:
  - Counter cleared on every key_valid and whenever state=ACCT with 0 digits entered; increments otherwise (ISSUE excluded).
  - Reaching TIMEOUT_CYCLES-1: timeout pulses 1 cycle, all fields cleared, state -> ACCT.
  - key_valid on the same cycle as expiry wins: the key is processed, counter cleared, no timeout.
- Reset mid-entry or mid-ISSUE: immediate return to reset values. A pending request is dropped, not delivered.
- error and timeout are never asserted together.

Test Plan:
- Keys 3,ENTER,1,2,3,4,ENTER,2,ENTER,5,0,0,ENTER, req_ready held 1 -> one req_valid cycle with acc_num=3, pin=16'h1234, operation=2, amount=500, new_pin=0; state back to 0.
- Keys 7,ENTER,9,9,9,9,ENTER,4,ENTER,4,3,2,1,ENTER with req_ready=0 for 5 cycles, then 1 -> req_valid stays high 5+ cycles with new_pin=16'h4321, operation=4; drops the cycle after ready; keys during ISSUE ignored.
- PIN entry 1,2,3,ENTER -> error pulse, pin=0, state=1; then 1,2,3,4,5 -> error on 5th digit, pin=16'h1234.
- OP digit 6 -> error, state 2; amount 9 digits of 9 -> 9th rejected, amount=99999999; ENTER with no amount digits -> error.
- TIMEOUT_CYCLES=20: enter 1,ENTER,1 then idle -> timeout pulse exactly 19 cycles after the last key, state=0, pin=0. A key at cycle 19 prevents the timeout.
- rst low mid-AMOUNT and during ISSUE -> outputs 0, state 0, no req_valid after rst release; CANCEL in NEWPIN -> state 0, no error.
